// File: rtl/alu_requester_pkg.sv
// Shared types for the ALU requester: opcode and FSM state encodings,
// plus the result value reported on a timed-out command.
package alu_req_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_e;

  localparam logic [15:0] RSP_ERR_RESULT = 16'h0000;

endpackage

// File: rtl/alu_requester_if.sv
// Command stream, ALU pin bundle and response stream of the ALU requester.
// master = requester side, slave = sequencer/ALU side.
interface alu_requester_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;

  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_error;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_A, alu_B, alu_op, alu_start,
    input  alu_done, alu_result,
    output rsp_valid, rsp_result, rsp_op, rsp_error,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_A, alu_B, alu_op, alu_start,
    output alu_done, alu_result,
    input  rsp_valid, rsp_result, rsp_op, rsp_error,
    output rsp_ready
  );

endinterface

// File: rtl/alu_requester.sv
// Initiator for the start/done ALU protocol: one command in flight, response
// held until accepted, then a start-low drain. ALU_REQ_TIMEOUT_EN adds an issue timeout.
module alu_requester
  import alu_req_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic        clk,
  input logic        reset_n,
  alu_requester_if.master bus
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_requester: DRAIN_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  state_e        state_q, state_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;

`ifdef ALU_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rsp_error_q, rsp_error_d;
`endif

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = alu_start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    drain_cnt_d  = drain_cnt_q;
`ifdef ALU_REQ_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    rsp_error_d  = rsp_error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
`ifdef ALU_REQ_TIMEOUT_EN
          to_cnt_d    = '0;
          rsp_error_d = 1'b0;
`endif
          // The ALU never raises done for NO_OP, so answer it locally.
          if (bus.cmd_op == NO_OP) begin
            rsp_result_d = '0;
            rsp_op_d     = bus.cmd_op;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else begin
            alu_start_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (bus.alu_done) begin
          rsp_result_d = bus.alu_result;
          rsp_op_d     = alu_op_q;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = RESP;
        end
`ifdef ALU_REQ_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d = RSP_ERR_RESULT;
          rsp_op_d     = alu_op_q;
          rsp_error_d  = 1'b1;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
          state_d     = DRAIN;
        end
      end

      DRAIN: begin
        // Any done pulse arriving here is stale and deliberately dropped.
        if (drain_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      drain_cnt_q  <= '0;
`ifdef ALU_REQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      drain_cnt_q  <= drain_cnt_d;
`ifdef ALU_REQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      rsp_error_q  <= rsp_error_d;
`endif
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.alu_A      = alu_a_q;
  assign bus.alu_B      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_op     = rsp_op_q;
`ifdef ALU_REQ_TIMEOUT_EN
  assign bus.rsp_error  = rsp_error_q;
`else
  assign bus.rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester: a behavioural ALU (1-cycle logic ops,
// 4-cycle multiply with a trailing late done) plus a table of commands.
module tb_alu_requester;

  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_requester_if bus ();

  alu_requester #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(15)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural ALU
  logic [3:0] mcnt = '0;
  logic       late_q = 1'b0;
  logic       spur_done = 1'b0;
  logic       block_done = 1'b0;
  logic [3:0] mlat;
  assign mlat = bus.alu_op[2] ? 4'd4 : 4'd1;

  always @(posedge clk) begin
    if (!bus.alu_start) mcnt <= '0;
    else if (mcnt != 4'hF) mcnt <= mcnt + 4'd1;
    late_q <= bus.alu_op[2] && bus.alu_start && (mcnt >= mlat);
  end

  assign bus.alu_done = !block_done &&
                        ((bus.alu_start && (mcnt >= mlat)) || late_q || spur_done);

  always_comb begin
    bus.alu_result = 16'h0000;
    if (bus.alu_op[2]) bus.alu_result = bus.alu_A * bus.alu_B;
    else if (bus.alu_op == 3'b001) bus.alu_result = {8'h00, 8'(bus.alu_A + bus.alu_B)};
    else if (bus.alu_op == 3'b010) bus.alu_result = {8'h00, bus.alu_A & bus.alu_B};
    else if (bus.alu_op == 3'b011) bus.alu_result = {8'h00, bus.alu_A ^ bus.alu_B};
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    int          lat;
    int          starts;
    int          hold;
    logic        err;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    int st;
    int noise;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    bus.cmd_a = v.a; bus.cmd_b = v.b; bus.cmd_op = v.op; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;                       // accept edge E0
    bus.cmd_valid = 1'b0;
    check("alu_pins_latched", {13'h0, bus.alu_A, bus.alu_B, bus.alu_op}, {13'h0, v.a, v.b, v.op});
    check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
    n = 0; st = 0;
    while (!bus.rsp_valid && n < 40) begin
      if (bus.alu_start) st++;
      @(posedge clk); #1; n++;
    end
    check("rsp_latency", 32'(n), 32'(v.lat));
    check("start_cycles", 32'(st), 32'(v.starts));
    check("start_low_at_rsp", 32'(bus.alu_start), 0);
    check("rsp_result", 32'(bus.rsp_result), 32'(v.res));
    check("rsp_op", 32'(bus.rsp_op), 32'(v.op));
    check("rsp_error", 32'(bus.rsp_error), 32'(v.err));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      check("rsp_hold", {11'h0, bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.cmd_ready},
                        {11'h0, 1'b1, v.res, v.op, 1'b0});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_cleared", 32'(bus.rsp_valid), 0);
    // Inject a stray done during the drain window; it must not produce anything.
    spur_done = 1'b1;
    n = 0; noise = 0;
    while (!bus.cmd_ready && n < 20) begin
      if (bus.alu_start || bus.rsp_valid) noise++;
      @(posedge clk); #1; spur_done = 1'b0; n++;
    end
    spur_done = 1'b0;
    check("drain_cycles", 32'(n), 32'(DRAIN));
    check("drain_quiet", 32'(noise + (bus.rsp_valid ? 1 : 0) + (bus.alu_start ? 1 : 0)), 0);
  endtask

  initial begin
    vec_t v;
    // a, b, op, result, rsp_valid edges after accept, start-high cycles, rsp_ready low cycles, error
    vecs[0] = '{8'hFF, 8'h01, 3'b001, 16'h0000, 2, 2, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 3'b100, 16'hFE01, 5, 5, 0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 3'b000, 16'h0000, 0, 0, 1, 1'b0}; // valid set on the accept edge
    vecs[3] = '{8'hF0, 8'h3C, 3'b011, 16'h00CC, 2, 2, 3, 1'b0};
    vecs[4] = '{8'hF0, 8'h3C, 3'b010, 16'h0030, 2, 2, 0, 1'b0};
    vecs[5] = '{8'h0C, 8'h0B, 3'b111, 16'h0084, 5, 5, 2, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 3'b001, 16'h0080, 2, 2, 0, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("reset_outputs", {7'h0, bus.alu_start, bus.rsp_valid, bus.rsp_error, bus.alu_A,
                            bus.alu_B, bus.alu_op, bus.cmd_ready},
                           {7'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1});
    check("reset_rsp", {13'h0, bus.rsp_result, bus.rsp_op}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Asynchronous reset two cycles into a multiply
    bus.cmd_a = 8'h55; bus.cmd_b = 8'h02; bus.cmd_op = 3'b100; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_mul_start", 32'(bus.alu_start), 1);
    reset_n = 1'b0;
    #1;
    check("async_reset", {12'h0, bus.alu_start, bus.rsp_valid, bus.cmd_ready, bus.alu_A,
                          bus.alu_B, bus.alu_op},
                         {12'h0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b000});
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    v = '{8'h03, 8'h04, 3'b001, 16'h0007, 2, 2, 0, 1'b0};
    run_cmd(v);

`ifdef ALU_REQ_TIMEOUT_EN
    block_done = 1'b1;
    v = '{8'h05, 8'h06, 3'b001, 16'h0000, 15, 15, 1, 1'b1};
    run_cmd(v);
    block_done = 1'b0;
    v = '{8'h01, 8'h01, 3'b001, 16'h0002, 2, 2, 0, 1'b0};
    run_cmd(v);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1);
  end

endmodule
